// File: rtl/k12a_alu_sequencer_pkg.sv
// Shared k12a ALU-sequencer types: operand select, sequencer states and
// the fixed instruction field positions used to decode the latched word.
package k12a_alu_sequencer_pkg;

    typedef enum logic {
        ALU_OPERAND_SEL_B    = 1'b0,
        ALU_OPERAND_SEL_INST = 1'b1
    } alu_operand_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } alu_seq_state_t;

    localparam int unsigned ALU_SEQ_OP_LSB  = 8;
    localparam int unsigned ALU_SEQ_SEL_BIT = 11;
    localparam int unsigned ALU_SEQ_WB_BIT  = 12;
    localparam int unsigned ALU_SEQ_CNT_MSB = 2;

    localparam logic [2:0] ALU_OP_SHR = 3'h6;

endpackage

// File: rtl/k12a_alu_sequencer.sv
// Sequences the k12a ALU for one instruction at a time; multi-bit shifts are
// built by repeating the single-bit arithmetic shift-right.
module k12a_alu_sequencer
    import k12a_alu_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      inst_in,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic [15:0]      inst,
    output logic             alu_load,
    output alu_operand_sel_t alu_operand_sel,
    output logic             a_load,
    output logic             busy,
    output logic             done
);

    alu_seq_state_t state, state_nx;
    logic [2:0]     remaining, remaining_nx;
    logic           done_nx;
    logic           ready_c, busy_c, alu_load_c, a_load_c;

    logic [2:0] op;
    logic [2:0] cnt;
    logic       wb;

    assign op  = inst[ALU_SEQ_OP_LSB +: 3];
    assign cnt = inst[ALU_SEQ_CNT_MSB:0];
    assign wb  = inst[ALU_SEQ_WB_BIT];

    always_comb begin
        alu_operand_sel = inst[ALU_SEQ_SEL_BIT] ? ALU_OPERAND_SEL_INST : ALU_OPERAND_SEL_B;
    end

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        done_nx      = 1'b0;
        ready_c      = 1'b0;
        busy_c       = 1'b0;
        alu_load_c   = 1'b0;
        a_load_c     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (inst_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                busy_c = 1'b1;
                if (op == ALU_OP_SHR && cnt == 3'd0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (op != ALU_OP_SHR || cnt == 3'd1) begin
                    alu_load_c = 1'b1;
                    a_load_c   = wb;
                    state_nx   = IDLE;
                    done_nx    = 1'b1;
                end else begin
                    // First of N shift steps happens here; SHIFT covers the other N-1.
                    alu_load_c   = 1'b1;
                    a_load_c     = 1'b1;
                    remaining_nx = cnt - 3'd1;
                    state_nx     = SHIFT;
                end
            end
            SHIFT: begin
                busy_c       = 1'b1;
                alu_load_c   = 1'b1;
                remaining_nx = remaining - 3'd1;
                if (remaining == 3'd1) begin
                    a_load_c = wb;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    a_load_c = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Reset masks the strobes combinationally so the reset edge writes nothing to A.
    assign inst_ready = ready_c    & ~reset;
    assign busy       = busy_c     & ~reset;
    assign alu_load   = alu_load_c & ~reset;
    assign a_load     = a_load_c   & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            inst      <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            done      <= done_nx;
            if (state == IDLE && inst_valid) begin
                inst <= inst_in;
            end
        end
    end

endmodule

// File: tb/tb_k12a_alu_sequencer.sv
// Directed bench for k12a_alu_sequencer: per-cycle strobe expectations are
// queued at issue time and popped each cycle; a small ALU/A model checks results.
module tb_k12a_alu_sequencer;
    import k12a_alu_sequencer_pkg::*;

    logic             clock;
    logic             reset;
    logic [15:0]      inst_in;
    logic             inst_valid;
    logic             inst_ready;
    logic [15:0]      inst;
    logic             alu_load;
    alu_operand_sel_t alu_operand_sel;
    logic             a_load;
    logic             busy;
    logic             done;

    k12a_alu_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .inst_in         (inst_in),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .alu_load        (alu_load),
        .alu_operand_sel (alu_operand_sel),
        .a_load          (a_load),
        .busy            (busy),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Minimal ALU + A register: op 1 = AND, op 6 = arithmetic shift right by one.
    logic [7:0] a_reg, b_reg, alu_result, a_set_val, operand;
    logic       a_set_en;

    always_comb begin
        operand    = inst[11] ? inst[7:0] : b_reg;
        alu_result = a_reg;
        case (inst[10:8])
            3'h1:    alu_result = a_reg & operand;
            3'h6:    alu_result = {a_reg[7], a_reg[7:1]};
            default: alu_result = a_reg;
        endcase
    end

    always @(posedge clock) begin
        if (a_set_en)    a_reg <= a_set_val;
        else if (a_load) a_reg <= alu_result;
    end

    typedef struct {
        string tag;
        logic  alu_load;
        logic  a_load;
        logic  busy;
        logic  done;
        logic  ready;
        logic  sel;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle outputs from acceptance until the done cycle.
    task automatic push_trace(input logic [15:0] w);
        logic [2:0] op, n;
        logic       wb, sel;
        exp_t       e;
        op  = w[10:8];
        n   = w[2:0];
        wb  = w[12];
        sel = w[11];
        if (op != 3'h6 || n == 3'd1) begin
            e = '{$sformatf("%h.exec", w), 1'b1, wb, 1'b1, 1'b0, 1'b0, sel};
            q.push_back(e);
        end else if (n == 3'd0) begin
            e = '{$sformatf("%h.exec", w), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sel};
            q.push_back(e);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                e = '{$sformatf("%h.c%0d", w, i), 1'b1, (i == int'(n) - 1) ? wb : 1'b1,
                      1'b1, 1'b0, 1'b0, sel};
                q.push_back(e);
            end
        end
        e = '{$sformatf("%h.done", w), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, sel};
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=nonzero", q.size());
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            check({e.tag, ".alu_load"}, 16'(alu_load), 16'(e.alu_load));
            check({e.tag, ".a_load"},   16'(a_load),   16'(e.a_load));
            check({e.tag, ".busy"},     16'(busy),     16'(e.busy));
            check({e.tag, ".done"},     16'(done),     16'(e.done));
            check({e.tag, ".ready"},    16'(inst_ready), 16'(e.ready));
            check({e.tag, ".sel"},      16'(alu_operand_sel), 16'(e.sel));
        end
    endtask

    task automatic issue(input logic [15:0] w);
        inst_in    = w;
        inst_valid = 1'b1;
        push_trace(w);
    endtask

    task automatic preset_a(input logic [7:0] v);
        a_set_val = v;
        a_set_en  = 1'b1;
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            @(negedge clock);
            a_set_en   = 1'b0;
            inst_valid = 1'b0;
            pop_check();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        inst_in    = '0;
        inst_valid = 1'b0;
        b_reg      = 8'h3C;
        a_set_val  = '0;
        a_set_en   = 1'b1;

        repeat (3) @(negedge clock);
        check("reset.ready", 16'(inst_ready), 16'h0);
        check("reset.busy",  16'(busy),       16'h0);
        reset    = 1'b0;
        a_set_en = 1'b0;

        @(negedge clock);
        check("idle.ready",    16'(inst_ready),      16'h1);
        check("idle.alu_load", 16'(alu_load),        16'h0);
        check("idle.a_load",   16'(a_load),          16'h0);
        check("idle.done",     16'(done),            16'h0);
        check("idle.busy",     16'(busy),            16'h0);
        check("idle.inst",     inst,                 16'h0000);
        check("idle.sel",      16'(alu_operand_sel), 16'(ALU_OPERAND_SEL_B));

        // AND with B, write back.
        preset_a(8'hF0);
        issue(16'h1104);
        drain();
        check("and.a", 16'(a_reg), 16'h0030);

        // Shift right by 5 with write back.
        preset_a(8'h80);
        issue(16'h1E05);
        drain();
        check("shr5.a", 16'(a_reg), 16'h00FC);

        // Shift right by 3, final write discarded.
        preset_a(8'h40);
        issue(16'h0E03);
        drain();
        check("shr3_dry.a", 16'(a_reg), 16'h0010);

        // Shift by zero is a no-op.
        issue(16'h1E00);
        drain();
        check("shr0.a", 16'(a_reg), 16'h0010);

        // Valid held high with junk during a shift; next accepted on the done cycle.
        preset_a(8'h80);
        issue(16'h1E03);
        while (q.size() > 1) begin
            @(negedge clock);
            a_set_en = 1'b0;
            inst_in  = 16'($urandom);
            pop_check();
            check("hold.inst", inst, 16'h1E03);
        end
        @(negedge clock);
        inst_in = 16'h1104;
        pop_check();
        check("hold.a", 16'(a_reg), 16'h00F0);
        push_trace(16'h1104);
        drain();
        check("b2b.inst", inst, 16'h1104);
        check("b2b.a",    16'(a_reg), 16'h0030);

        // Reset during the third cycle of a 7-step shift.
        preset_a(8'h80);
        issue(16'h1E07);
        repeat (3) begin
            @(negedge clock);
            a_set_en   = 1'b0;
            inst_valid = 1'b0;
            pop_check();
        end
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        check("rst_mid.alu_load", 16'(alu_load),   16'h0);
        check("rst_mid.a_load",   16'(a_load),     16'h0);
        check("rst_mid.busy",     16'(busy),       16'h0);
        check("rst_mid.done",     16'(done),       16'h0);
        check("rst_mid.ready",    16'(inst_ready), 16'h0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_after.done",  16'(done),       16'h0);
        check("rst_after.busy",  16'(busy),       16'h0);
        check("rst_after.ready", 16'(inst_ready), 16'h1);
        check("rst_after.inst",  inst,            16'h0000);
        check("rst_after.a",     16'(a_reg),      16'h00E0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
